// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the two-port SDRAM arbiter.
package sdram_arb_pkg;

  localparam int ARB_ADDR_WIDTH = 32;
  localparam int ARB_DATA_WIDTH = 32;

  localparam logic [31:0] TIMEOUT_DATA = 32'hDEADBEEF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2,
    RESP    = 2'd3
  } arb_state_t;

  typedef struct packed {
    logic [ARB_ADDR_WIDTH-1:0]   addr;
    logic                        we;
    logic [ARB_DATA_WIDTH-1:0]   wdata;
    logic [ARB_DATA_WIDTH/8-1:0] wstrb;
  } arb_req_t;

endpackage

// File: rtl/sdram_arbiter_if.sv
// Bundles both requester ports and the SDRAM controller native port.
// Handshake: a requester holds i_mN_valid (and stable payload) until o_mN_ready
// pulses for one cycle; o_sdr_req is held until i_sdr_ack is sampled high.
interface sdram_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int STRB_W = DATA_WIDTH / 8;

  logic                  i_m0_valid;
  logic [ADDR_WIDTH-1:0] i_m0_addr;
  logic                  i_m0_we;
  logic [DATA_WIDTH-1:0] i_m0_wdata;
  logic [STRB_W-1:0]     i_m0_wstrb;
  logic                  o_m0_ready;
  logic [DATA_WIDTH-1:0] o_m0_rdata;

  logic                  i_m1_valid;
  logic [ADDR_WIDTH-1:0] i_m1_addr;
  logic                  i_m1_we;
  logic [DATA_WIDTH-1:0] i_m1_wdata;
  logic [STRB_W-1:0]     i_m1_wstrb;
  logic                  o_m1_ready;
  logic [DATA_WIDTH-1:0] o_m1_rdata;

  logic                  o_sdr_req;
  logic                  i_sdr_ack;
  logic [ADDR_WIDTH-1:0] o_sdr_addr;
  logic                  o_sdr_we;
  logic [DATA_WIDTH-1:0] o_sdr_wdata;
  logic [STRB_W-1:0]     o_sdr_dm;
  logic                  i_sdr_rvalid;
  logic [DATA_WIDTH-1:0] i_sdr_rdata;
  logic                  o_timeout;

  modport slave (
    input  i_m0_valid, i_m0_addr, i_m0_we, i_m0_wdata, i_m0_wstrb,
    output o_m0_ready, o_m0_rdata,
    input  i_m1_valid, i_m1_addr, i_m1_we, i_m1_wdata, i_m1_wstrb,
    output o_m1_ready, o_m1_rdata,
    output o_sdr_req, o_sdr_addr, o_sdr_we, o_sdr_wdata, o_sdr_dm, o_timeout,
    input  i_sdr_ack, i_sdr_rvalid, i_sdr_rdata
  );

  modport master (
    output i_m0_valid, i_m0_addr, i_m0_we, i_m0_wdata, i_m0_wstrb,
    input  o_m0_ready, o_m0_rdata,
    output i_m1_valid, i_m1_addr, i_m1_we, i_m1_wdata, i_m1_wstrb,
    input  o_m1_ready, o_m1_rdata,
    input  o_sdr_req, o_sdr_addr, o_sdr_we, o_sdr_wdata, o_sdr_dm, o_timeout,
    output i_sdr_ack, i_sdr_rvalid, i_sdr_rdata
  );

endinterface

// File: rtl/sdram_arb_rr2.sv
// Combinational two-way picker: round-robin on ties, or port 0 first when FIXED_PRIO is set.
module sdram_arb_rr2 #(
  parameter int FIXED_PRIO = 0
) (
  input  logic [1:0] i_valid,
  input  logic       i_last_grant,
  output logic       o_winner,
  output logic       o_any
);

  always_comb begin
    o_any    = |i_valid;
    o_winner = 1'b0;
    if (i_valid == 2'b10) begin
      o_winner = 1'b1;
    end else if (i_valid == 2'b11) begin
      o_winner = (FIXED_PRIO != 0) ? 1'b0 : ~i_last_grant;
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// Shares the SDRAM controller native port between the CPU bridge (port 0) and
// the SD-card DMA (port 1), one single-word transaction at a time, with a read watchdog.
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH     = ARB_ADDR_WIDTH,
  parameter int DATA_WIDTH     = ARB_DATA_WIDTH,
  parameter int FIXED_PRIO     = 0,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic       i_sysclk,
  input  logic       i_rst,
  sdram_arbiter_if.slave bus,
  output arb_state_t o_state
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int CNT_W  = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  arb_state_t            r_state;
  arb_state_t            w_next_state;
  logic                  r_grant;
  logic                  r_last_grant;
  logic [CNT_W-1:0]      r_cnt;
  logic [ADDR_WIDTH-1:0] r_sdr_addr;
  logic                  r_sdr_we;
  logic [DATA_WIDTH-1:0] r_sdr_wdata;
  logic [STRB_W-1:0]     r_sdr_dm;
  logic [DATA_WIDTH-1:0] r_m0_rdata;
  logic [DATA_WIDTH-1:0] r_m1_rdata;
  logic                  r_timeout;
  logic                  w_winner;
  logic                  w_any;
  logic                  w_timeout_hit;
  arb_req_t              w_req;

  sdram_arb_rr2 #(.FIXED_PRIO(FIXED_PRIO)) u_rr2 (
    .i_valid      ({bus.i_m1_valid, bus.i_m0_valid}),
    .i_last_grant (r_last_grant),
    .o_winner     (w_winner),
    .o_any        (w_any)
  );

  always_comb begin
    w_req.addr  = bus.i_m0_addr;
    w_req.we    = bus.i_m0_we;
    w_req.wdata = bus.i_m0_wdata;
    w_req.wstrb = bus.i_m0_wstrb;
    if (w_winner) begin
      w_req.addr  = bus.i_m1_addr;
      w_req.we    = bus.i_m1_we;
      w_req.wdata = bus.i_m1_wdata;
      w_req.wstrb = bus.i_m1_wstrb;
    end
  end

  assign w_timeout_hit = (r_cnt == CNT_LAST);

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_any) w_next_state = ISSUE;
      ISSUE:   if (bus.i_sdr_ack) w_next_state = r_sdr_we ? RESP : WAIT_RD;
      WAIT_RD: if (bus.i_sdr_rvalid || w_timeout_hit) w_next_state = RESP;
      RESP:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Each port keeps its own response register so the idle port's rdata holds.
  always_ff @(posedge i_sysclk) begin
    if (i_rst) begin
      r_state      <= IDLE;
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
      r_cnt        <= '0;
      r_sdr_addr   <= '0;
      r_sdr_we     <= 1'b0;
      r_sdr_wdata  <= '0;
      r_sdr_dm     <= '1;
      r_m0_rdata   <= '0;
      r_m1_rdata   <= '0;
      r_timeout    <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_timeout <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_grant      <= w_winner;
            r_last_grant <= w_winner;
            r_sdr_addr   <= w_req.addr;
            r_sdr_we     <= w_req.we;
            r_sdr_wdata  <= w_req.wdata;
            r_sdr_dm     <= ~w_req.wstrb;
          end
        end
        ISSUE: begin
          if (bus.i_sdr_ack && !r_sdr_we) r_cnt <= '0;
        end
        WAIT_RD: begin
          if (bus.i_sdr_rvalid) begin
            if (r_grant) r_m1_rdata <= bus.i_sdr_rdata;
            else         r_m0_rdata <= bus.i_sdr_rdata;
          end else if (w_timeout_hit) begin
            if (r_grant) r_m1_rdata <= DATA_WIDTH'(TIMEOUT_DATA);
            else         r_m0_rdata <= DATA_WIDTH'(TIMEOUT_DATA);
            r_timeout <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.o_sdr_req   = (r_state == ISSUE);
  assign bus.o_sdr_addr  = r_sdr_addr;
  assign bus.o_sdr_we    = r_sdr_we;
  assign bus.o_sdr_wdata = r_sdr_wdata;
  assign bus.o_sdr_dm    = r_sdr_dm;
  assign bus.o_timeout   = r_timeout;
  assign bus.o_m0_ready  = (r_state == RESP) && !r_grant;
  assign bus.o_m1_ready  = (r_state == RESP) && r_grant;
  assign bus.o_m0_rdata  = r_m0_rdata;
  assign bus.o_m1_rdata  = r_m1_rdata;
  assign o_state         = r_state;

endmodule
